regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Debug/readback engine that walks a contiguous, optionally wrapping, range of the register file through one combinational read port.
- Streams each register out on a valid/ready interface, tagged with its index.
- Sits beside the register file and owns one read address, in parallel with the core's normal writes and reads.
- Used by the debug/trace path to dump architectural state without stalling writes.

Parameters:
- DataWidth, 16, register width in bits.
- NumRegs, 16, number of registers; need not be a power of two.
- IndexWidth, $clog2(NumRegs), width of register indices.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- firstAddr  in  IndexWidth  first register to dump; sampled with start.
- lastAddr  in  IndexWidth  last register to dump, inclusive; sampled with start.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse after the final beat's handshake.
- rfReadAddr  out  IndexWidth  read address driven to the register file.
- rfReadData  in  DataWidth  combinational read data returned for rfReadAddr.
- outValid  out  1  stream beat valid.
- outReady  in  1  downstream accepts the beat.
- outData  out  DataWidth  register value for this beat.
- outIndex  out  IndexWidth  register index for this beat.
- outLast  out  1  marks the final beat of the dump.

Behaviour:
- Clock is clk; reset rst is asynchronous and active-high.
- Reset state: IDLE, with busy, done, outValid and outLast = 0, and outData, outIndex and rfReadAddr = 0.
- FSM states:
  - IDLE: on start, latch cur=firstAddr and end=lastAddr, then go to FETCH. Otherwise stay.
  - FETCH: drive rfReadAddr=cur. On the clock edge, register outData=rfReadData, outIndex=cur, and outLast=(cur==end), set outValid=1, and go to SEND.
  - SEND: hold outValid, outData, outIndex and outLast stable while outReady=0. On outValid&&outReady:
    - if outLast, go to DONE;
    - else cur=next(cur) and go to FETCH.
    - outValid drops in the same edge.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- next(cur): cur==NumRegs-1 ? 0 : cur+1. Wrap is independent of power-of-two sizing.
- firstAddr>lastAddr: the dump wraps, e.g. 14,15,0,1 for NumRegs=16.
- firstAddr==lastAddr: exactly one beat, with outLast=1.
- Address inputs ≥NumRegs are undefined use. The block clamps them to NumRegs-1 at capture.
- Latency: start at edge N, FETCH in cycle N+1, first outValid visible in cycle N+2. Throughput is one beat per 2 cycles with outReady held high.
- start while busy, or in DONE, is ignored with no queuing.
- Value returned for a register written while the dump is in progress: whatever rfReadData shows in its FETCH cycle, with no snapshot.
- rfReadAddr holds cur in all non-IDLE states and 0 in IDLE.
- rst asserted mid-dump: outputs clear immediately and asynchronously. No done pulse is produced, and the next dump requires a fresh start.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- Defined:
  - After the final register beat, one extra beat is emitted with outData = XOR of all outData values sent in this dump, outIndex=0 and outLast=1.
  - Register beats never assert outLast.
  - A CHECKSUM state sits between the last register handshake and DONE, and obeys the same hold rules under backpressure.
  - The accumulator clears on an accepted start.
- Not defined: no accumulator, no extra state, and outLast is on the final register beat.

Test Plan:
- Reset: assert rst mid-cycle → busy, done, outValid, outLast, outData and outIndex read 0 asynchronously, before the next clock.
- Full dump: regs[i]=16'h1111*i, first=0, last=15, outReady=1 → 16 beats with index 0..15 and data 0000..FFFF, first outValid 2 cycles after start, outLast on index 15, and a single done pulse 1 cycle after that handshake.
- Backpressure: same setup, outReady=0 for 3 cycles while the index-5 beat is valid → outData=5555 and outIndex=5 held stable throughout, then the index-6 beat follows after release.
- Wrap and single: first=14, last=1 → indices 14,15,0,1 with outLast on 1. first=last=7 → one beat with outLast=1. A start pulsed during busy leaves the sequence unchanged.
- Reset mid-dump: rst after the index-3 handshake → no further beats and no done. A new start with first=0, last=2 yields indices 0,1,2.
- Checksum (macro on): regs 0..3 = 0001, 0002, 0004, 0008, dump 0..3 → 4 register beats with outLast=0, then a beat with data=000F, index 0 and outLast=1, then done.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: walks [firstAddr..lastAddr] with wrap and streams beats.
// Optional trailing XOR checksum beat when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
  parameter int DataWidth  = 16,
  parameter int NumRegs    = 16,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IndexWidth-1:0] firstAddr,
  input  logic [IndexWidth-1:0] lastAddr,
  output logic                  busy,
  output logic                  done,
  output logic [IndexWidth-1:0] rfReadAddr,
  input  logic [DataWidth-1:0]  rfReadData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DataWidth-1:0]  outData,
  output logic [IndexWidth-1:0] outIndex,
  output logic                  outLast
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, SEND, CKSUM, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, FETCH, SEND, DONE
  } state_t;
`endif

  localparam logic [IndexWidth-1:0] MaxIdx =
    IndexWidth'(NumRegs - 1);

  state_t state, nstate;
  logic [IndexWidth-1:0] cur, endq;
  logic hs, at_end;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DataWidth-1:0] acc;
`endif

  assign hs     = outValid && outReady;
  assign at_end = (cur == endq);

  function automatic logic [IndexWidth-1:0] clamp(
    input logic [IndexWidth-1:0] a
  );
    return (a > MaxIdx) ? MaxIdx : a;
  endfunction

  function automatic logic [IndexWidth-1:0] nxt(
    input logic [IndexWidth-1:0] a
  );
    return (a == MaxIdx) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (start) nstate = FETCH;
      FETCH: nstate = SEND;
      SEND: begin
        if (hs) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          nstate = at_end ? CKSUM : FETCH;
`else
          nstate = at_end ? DONE : FETCH;
`endif
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      CKSUM: if (hs) nstate = DONE;
`endif
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    rfReadAddr = (state == IDLE) ? '0 : cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= '0;
      endq     <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      outIndex <= '0;
      outLast  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc      <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        cur  <= clamp(firstAddr);
        endq <= clamp(lastAddr);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc  <= '0;
`endif
      end
      if (state == FETCH) begin
        outValid <= 1'b1;
        outData  <= rfReadData;
        outIndex <= cur;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        outLast  <= 1'b0;
`else
        outLast  <= at_end;
`endif
      end
      if (state == SEND && hs) begin
        outValid <= 1'b0;
        if (!at_end) cur <= nxt(cur);
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc <= acc ^ outData;
        // checksum beat follows the last register beat directly
        if (at_end) begin
          outValid <= 1'b1;
          outData  <= acc ^ outData;
          outIndex <= '0;
          outLast  <= 1'b1;
        end
`endif
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      if (state == CKSUM && hs) outValid <= 1'b0;
`endif
    end
  end

endmodule
